color_identify_core: RTL and testbench

Pixel-rate colour classifier in the camera video path, between the sensor capture interface and downstream blob/position logic. Each RGB565 pixel is converted to YCbCr and tested against a programmable colour window; default: saturated blue. A 1-bit per-pixel match flag `img_en` is produced with fixed latency.

---
 rtl/color_identify_core_if.sv | 26 ++
 rtl/color_identify_core.sv | 145 ++++++++++++++
 tb/tb_color_identify_core.sv | 130 +++++++++++++
 3 files changed

// File: rtl/color_identify_core_if.sv
// Pixel bus between the sensor capture side and the colour classifier.
// master: capture side (drives qualifiers and pixel, receives match flag).
// slave : classifier core.
interface color_identify_core_if;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [15:0] img_data;
  logic        img_en;

  modport master (
    output per_frame_vsync,
    output per_frame_href,
    output per_frame_clken,
    output img_data,
    input  img_en
  );

  modport slave (
    input  per_frame_vsync,
    input  per_frame_href,
    input  per_frame_clken,
    input  img_data,
    output img_en
  );
endinterface

// File: rtl/color_identify_core.sv
// color_identify_core: RGB565 -> YCbCr per pixel, then a programmable
// Y/Cb/Cr window test. Three register stages, one pixel per clock, no stall.
// Optional build macro: COLOR_IDENTIFY_DENOISE_EN adds a per-line run filter
// so a match is only reported on the third consecutive matching pixel.
module color_identify_core #(
  parameter logic [7:0] Y_MIN  = 8'd0,
  parameter logic [7:0] Y_MAX  = 8'd255,
  parameter logic [7:0] CB_MIN = 8'd150,
  parameter logic [7:0] CB_MAX = 8'd255,
  parameter logic [7:0] CR_MIN = 8'd0,
  parameter logic [7:0] CR_MAX = 8'd120
) (
  input  logic                 clk,
  input  logic                 rst,
  color_identify_core_if.slave pix
);

  // product slots: three per output channel
  localparam int P_YR  = 0;
  localparam int P_YG  = 1;
  localparam int P_YB  = 2;
  localparam int P_CBR = 3;
  localparam int P_CBG = 4;
  localparam int P_CBB = 5;
  localparam int P_CRR = 6;
  localparam int P_CRG = 7;
  localparam int P_CRB = 8;

  // Inclusive window test done with 9-bit differences; an empty window
  // (lo > hi) can never satisfy both sides.
  function automatic logic in_win(input logic [7:0] v, input logic [7:0] lo,
                                  input logic [7:0] hi);
    logic [8:0] d_lo;
    logic [8:0] d_hi;
    d_lo = {1'b0, v} - {1'b0, lo};
    d_hi = {1'b0, hi} - {1'b0, v};
    return ~d_lo[8] & ~d_hi[8];
  endfunction

  logic              pix_vld;
  logic [7:0]        r8, g8, b8;
  logic [8:0][15:0]  prod_d, prod_q;
  logic [2:1]        vld_pipe_d, vld_pipe_q;
  logic [17:0]       y_sum, cb_sum, cr_sum;
  logic [7:0]        y_d, y_q, cb_d, cb_q, cr_d, cr_q;
  logic              win_hit;
  logic              img_en_d, img_en_q;
  logic              unused_sum_bits;

`ifdef COLOR_IDENTIFY_DENOISE_EN
  logic [2:1]        href_pipe_d, href_pipe_q;
  logic [1:0]        run_cnt_d, run_cnt_q;
`endif

  // Stage 1: qualify pixel, expand to 8 bits, form the nine products
  always_comb begin
    pix_vld = pix.per_frame_vsync & pix.per_frame_href & pix.per_frame_clken;
    r8 = {pix.img_data[15:11], pix.img_data[15:13]};
    g8 = {pix.img_data[10:5],  pix.img_data[10:9]};
    b8 = {pix.img_data[4:0],   pix.img_data[4:2]};
    prod_d        = '0;
    prod_d[P_YR]  = 16'(r8) * 16'd77;
    prod_d[P_YG]  = 16'(g8) * 16'd150;
    prod_d[P_YB]  = 16'(b8) * 16'd29;
    prod_d[P_CBR] = 16'(r8) * 16'd43;
    prod_d[P_CBG] = 16'(g8) * 16'd85;
    prod_d[P_CBB] = 16'(b8) * 16'd128;
    prod_d[P_CRR] = 16'(r8) * 16'd128;
    prod_d[P_CRG] = 16'(g8) * 16'd107;
    prod_d[P_CRB] = 16'(b8) * 16'd21;
    vld_pipe_d    = {vld_pipe_q[1], pix_vld};
  end

  // Stage 2: sum products in 18-bit two's complement and keep bits [15:8];
  // the coefficients keep every result inside 0..65535, so no clamping.
  always_comb begin
    y_sum  = 18'(prod_q[P_YR]) + 18'(prod_q[P_YG]) + 18'(prod_q[P_YB]);
    cb_sum = 18'd32768 + 18'(prod_q[P_CBB]) - 18'(prod_q[P_CBR])
           - 18'(prod_q[P_CBG]);
    cr_sum = 18'd32768 + 18'(prod_q[P_CRR]) - 18'(prod_q[P_CRG])
           - 18'(prod_q[P_CRB]);
    y_d  = y_sum[15:8];
    cb_d = cb_sum[15:8];
    cr_d = cr_sum[15:8];
  end

  // discarded fraction byte and always-zero top bits of the sums
  assign unused_sum_bits = ^{y_sum[17:16], y_sum[7:0], cb_sum[17:16],
                             cb_sum[7:0], cr_sum[17:16], cr_sum[7:0]};

`ifdef COLOR_IDENTIFY_DENOISE_EN
  // Stage 3: window test gated by a saturating run of matches within a line
  always_comb begin
    win_hit     = in_win(y_q, Y_MIN, Y_MAX) & in_win(cb_q, CB_MIN, CB_MAX)
                & in_win(cr_q, CR_MIN, CR_MAX);
    href_pipe_d = {href_pipe_q[1], pix.per_frame_href};
    run_cnt_d   = run_cnt_q;
    if (!href_pipe_q[2]) begin
      run_cnt_d = 2'd0;
    end else if (vld_pipe_q[2]) begin
      if (!win_hit)                run_cnt_d = 2'd0;
      else if (run_cnt_q != 2'd3)  run_cnt_d = run_cnt_q + 2'd1;
    end
    // counter value before this pixel must already be >= 2
    img_en_d = vld_pipe_q[2] & win_hit & run_cnt_q[1];
  end
`else
  // Stage 3: raw per-pixel window test
  always_comb begin
    win_hit  = in_win(y_q, Y_MIN, Y_MAX) & in_win(cb_q, CB_MIN, CB_MAX)
             & in_win(cr_q, CR_MIN, CR_MAX);
    img_en_d = vld_pipe_q[2] & win_hit;
  end
`endif

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q      <= '0;
      vld_pipe_q  <= '0;
      y_q         <= '0;
      cb_q        <= '0;
      cr_q        <= '0;
      img_en_q    <= 1'b0;
`ifdef COLOR_IDENTIFY_DENOISE_EN
      href_pipe_q <= '0;
      run_cnt_q   <= '0;
`endif
    end else begin
      prod_q      <= prod_d;
      vld_pipe_q  <= vld_pipe_d;
      y_q         <= y_d;
      cb_q        <= cb_d;
      cr_q        <= cr_d;
      img_en_q    <= img_en_d;
`ifdef COLOR_IDENTIFY_DENOISE_EN
      href_pipe_q <= href_pipe_d;
      run_cnt_q   <= run_cnt_d;
`endif
    end
  end

  assign pix.img_en = img_en_q;

endmodule

// File: tb/tb_color_identify_core.sv
// Directed bench for color_identify_core. Four instances share the stimulus:
// default window, CB_MIN=181, CB_MIN=182 and an empty Y window (MIN > MAX).
// Expected match bits per pixel are hand-computed constants:
//   blue 0x001F : Y=28  Cb=255 Cr=107
//   P1  (Cb181) : Y=144 Cb=181 Cr=95
//   100         : Y=10  Cb=140 Cr=120
//   140         : Cb=172 Cr=113
//   0           : Y=0   Cb=128 Cr=128
module tb_color_identify_core;

  localparam logic [15:0] BLUE = 16'b00000_000000_11111;
  localparam logic [15:0] P1   = 16'b01100_100101_11101;
  localparam logic [15:0] P100 = 16'd100;
  localparam logic [15:0] P140 = 16'd140;
  localparam logic [15:0] ZERO = 16'd0;
  // match bits: [0] default, [1] CB_MIN=181, [2] CB_MIN=182, [3] empty Y window
  localparam logic [3:0]  M_BLUE = 4'b0111;
  localparam logic [3:0]  M_P1   = 4'b0011;
  localparam logic [3:0]  M_P100 = 4'b0000;
  localparam logic [3:0]  M_P140 = 4'b0001;
  localparam logic [3:0]  M_ZERO = 4'b0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] hist [3];
`ifdef COLOR_IDENTIFY_DENOISE_EN
  logic [1:0] run_cnt [4];
`endif

  always #5 clk = ~clk;

  color_identify_core_if bus0 ();
  color_identify_core_if bus1 ();
  color_identify_core_if bus2 ();
  color_identify_core_if bus3 ();

  color_identify_core u_dflt (.clk(clk), .rst(rst), .pix(bus0));
  color_identify_core #(.CB_MIN(8'd181)) u_cb181 (.clk(clk), .rst(rst), .pix(bus1));
  color_identify_core #(.CB_MIN(8'd182)) u_cb182 (.clk(clk), .rst(rst), .pix(bus2));
  color_identify_core #(.Y_MIN(8'd200), .Y_MAX(8'd100)) u_empty (.clk(clk), .rst(rst), .pix(bus3));

  // Drive one cycle of stimulus, then check img_en for the pixel applied
  // two steps earlier (three edges after it was applied).
  task automatic step(input string tag, input logic r, input logic vs,
                      input logic hr, input logic ce, input logic [15:0] d,
                      input logic [3:0] m);
    logic       v;
    logic [3:0] e;
    logic [3:0] obs;
    v   = vs & hr & ce;
    rst = r;
    bus0.per_frame_vsync = vs; bus0.per_frame_href = hr; bus0.per_frame_clken = ce; bus0.img_data = d;
    bus1.per_frame_vsync = vs; bus1.per_frame_href = hr; bus1.per_frame_clken = ce; bus1.img_data = d;
    bus2.per_frame_vsync = vs; bus2.per_frame_href = hr; bus2.per_frame_clken = ce; bus2.img_data = d;
    bus3.per_frame_vsync = vs; bus3.per_frame_href = hr; bus3.per_frame_clken = ce; bus3.img_data = d;
    for (int i = 0; i < 4; i++) begin
      e[i] = v & m[i] & ~r;
`ifdef COLOR_IDENTIFY_DENOISE_EN
      e[i] = e[i] & run_cnt[i][1];
      if (r || !hr)  run_cnt[i] = 2'd0;
      else if (v)    run_cnt[i] = !m[i] ? 2'd0 : (run_cnt[i] == 2'd3) ? 2'd3 : run_cnt[i] + 2'd1;
`endif
    end
    @(posedge clk);
    #1;
    if (r) begin
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
    end else begin
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = e;
    end
    obs = {bus3.img_en, bus2.img_en, bus1.img_en, bus0.img_en};
    for (int i = 0; i < 4; i++) begin
      checks++;
      assert (obs[i] === hist[2][i]) else begin
        errors++;
        $error("FAIL %s inst%0d t=%0t: img_en observed %b expected %b",
               tag, i, $time, obs[i], hist[2][i]);
      end
    end
  endtask

  initial begin
    hist[0] = '0; hist[1] = '0; hist[2] = '0;
`ifdef COLOR_IDENTIFY_DENOISE_EN
    for (int i = 0; i < 4; i++) run_cnt[i] = 2'd0;
`endif
    rst = 1'b1;

    // reset with qualifiers high, then three idle cycles of zero data
    repeat (3) step("reset", 1'b1, 1'b1, 1'b1, 1'b1, ZERO, M_ZERO);
    repeat (3) step("post_reset", 1'b0, 1'b1, 1'b1, 1'b1, ZERO, M_ZERO);

    // sustained pure blue
    repeat (6) step("blue_hold", 1'b0, 1'b1, 1'b1, 1'b1, BLUE, M_BLUE);

    // pixel switches: match, no match, match
    repeat (4) step("p1_cb181", 1'b0, 1'b1, 1'b1, 1'b1, P1,   M_P1);
    repeat (4) step("p100",     1'b0, 1'b1, 1'b1, 1'b1, P100, M_P100);
    repeat (4) step("p140",     1'b0, 1'b1, 1'b1, 1'b1, P140, M_P140);

    // one qualifier toggling at a time
    for (int i = 0; i < 8; i++) step("clken_toggle", 1'b0, 1'b1, 1'b1, i[0], BLUE, M_BLUE);
    for (int i = 0; i < 8; i++) step("href_toggle",  1'b0, 1'b1, i[0], 1'b1, BLUE, M_BLUE);
    for (int i = 0; i < 8; i++) step("vsync_toggle", 1'b0, i[0], 1'b1, 1'b1, BLUE, M_BLUE);

    // line gap, then blue, blue, 100, blue x3 in one line
    repeat (2) step("line_gap", 1'b0, 1'b1, 1'b0, 1'b1, BLUE, M_BLUE);
    step("run_a", 1'b0, 1'b1, 1'b1, 1'b1, BLUE, M_BLUE);
    step("run_a", 1'b0, 1'b1, 1'b1, 1'b1, BLUE, M_BLUE);
    step("run_a", 1'b0, 1'b1, 1'b1, 1'b1, P100, M_P100);
    repeat (3) step("run_a", 1'b0, 1'b1, 1'b1, 1'b1, BLUE, M_BLUE);
    // href drop and line restart
    repeat (2) step("line_gap2", 1'b0, 1'b1, 1'b0, 1'b1, BLUE, M_BLUE);
    repeat (4) step("run_b", 1'b0, 1'b1, 1'b1, 1'b1, BLUE, M_BLUE);

    // reset mid-line discards in-flight pixels
    repeat (3) step("pre_mid_rst", 1'b0, 1'b1, 1'b1, 1'b1, BLUE, M_BLUE);
    step("mid_rst", 1'b1, 1'b1, 1'b1, 1'b1, BLUE, M_BLUE);
    repeat (5) step("after_mid_rst", 1'b0, 1'b1, 1'b1, 1'b1, BLUE, M_BLUE);

    // flush
    repeat (4) step("flush", 1'b0, 1'b1, 1'b1, 1'b1, ZERO, M_ZERO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
